// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - frame geometry and capture FSM encoding shared by the camera path
package cam_pkg;
    localparam int H_PIX       = 320;
    localparam int V_LINES     = 240;
    localparam int FRAME_WORDS = H_PIX * V_LINES;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SYNC   = 2'd1,
        ACTIVE = 2'd2,
        DONE   = 2'd3
    } state_e;
endpackage

// File: rtl/edge_det.sv
// rtl/edge_det.sv - registered rise/fall detector for a 1-bit level already in the clk domain
module edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise,
    output logic fall
);
    logic prev_q, prev_d;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    always_comb begin
        prev_d = d;
        rise_d = d & ~prev_q;
        fall_d = ~d & prev_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
endmodule

// File: rtl/cam_capture.sv
// rtl/cam_capture.sv - byte-serial RGB565 camera capture into linear buffer writes
module cam_capture #(
    parameter int H_PIX   = cam_pkg::H_PIX,
    parameter int V_LINES = cam_pkg::V_LINES,
    parameter int AW      = 17,
    parameter int DW      = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          capture_en,
    input  logic          vsync,
    input  logic          href,
    input  logic          px_en,
    input  logic [7:0]    px_data,
    output logic [AW-1:0] addr_in,
    output logic [DW-1:0] data_in,
    output logic          regwrite,
    output logic          frame_done,
    output logic          frame_ok,
    output logic          busy
);
    import cam_pkg::*;

    localparam int NW = H_PIX * V_LINES;
    // one extra bit so a full frame count is distinguishable from address 0
    localparam int CW = AW + 1;

    logic vs_rise, vs_fall, href_fall, href_rise_unused;

    edge_det u_vs_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (vsync),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    edge_det u_href_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (href),
        .rise (href_rise_unused),
        .fall (href_fall)
    );

    state_e          state_q, state_d;
    logic            phase_q, phase_d;
    logic [7:0]      hi_q, hi_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            lerr_q, lerr_d;
    logic            wr_q, wr_d;
    logic [DW-1:0]   data_q, data_d;
    logic            done_q, done_d;
    logic            ok_q, ok_d;
    logic            busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        hi_d    = hi_q;
        // the address advances in the cycle after the strobe, so addr_in holds during it
        count_d = count_q + CW'(wr_q);
        ovf_d   = ovf_q;
        lerr_d  = lerr_q;
        wr_d    = 1'b0;
        data_d  = data_q;
        done_d  = 1'b0;
        ok_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (capture_en && vsync) state_d = SYNC;
            end
            SYNC: begin
                if (vs_fall) begin
                    state_d = ACTIVE;
                    count_d = '0;
                    phase_d = 1'b0;
                    ovf_d   = 1'b0;
                    lerr_d  = 1'b0;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    ok_d    = (count_d == CW'(NW)) && !ovf_q && !lerr_q;
                end else if (href_fall && phase_q) begin
                    lerr_d  = 1'b1;
                    phase_d = 1'b0;
                end else if (px_en && href && !vsync) begin
                    // bytes seen while vsync is high belong to blanking, so vsync wins a collision
                    if (!phase_q) begin
                        hi_d    = px_data;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (count_q == CW'(NW)) begin
                            ovf_d = 1'b1;
                        end else begin
                            wr_d   = 1'b1;
                            data_d = DW'({hi_q, px_data});
                        end
                    end
                end
            end
            DONE: begin
                state_d = capture_en ? SYNC : IDLE;
            end
        endcase

        busy_d = (state_d == ACTIVE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            hi_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            lerr_q  <= 1'b0;
            wr_q    <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            hi_q    <= hi_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            lerr_q  <= lerr_d;
            wr_q    <= wr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            busy_q  <= busy_d;
        end
    end

    assign addr_in    = count_q[AW-1:0];
    assign data_in    = data_q;
    assign regwrite   = wr_q;
    assign frame_done = done_q;
    assign frame_ok   = ok_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_cam_capture.sv
// tb/tb_cam_capture.sv - randomized self-checking bench for cam_capture against a frame-level model
module tb_cam_capture;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int NW = H * V;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          capture_en = 1'b0;
    logic          vsync = 1'b0;
    logic          href = 1'b0;
    logic          px_en = 1'b0;
    logic [7:0]    px_data = 8'h00;
    logic [AW-1:0] addr_in;
    logic [DW-1:0] data_in;
    logic          regwrite, frame_done, frame_ok, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] obs_q[$];
    int          done_cyc[$];
    logic        done_ok[$];
    logic [31:0] exp_q[$];
    logic [7:0]  q_bytes[$];
    int          q_len[$];
    logic [7:0]  rb[12];
    int          ob0;

    cam_capture #(.H_PIX(H), .V_LINES(V), .AW(AW), .DW(DW)) dut (
        .clk        (clk),
        .rst        (rst),
        .capture_en (capture_en),
        .vsync      (vsync),
        .href       (href),
        .px_en      (px_en),
        .px_data    (px_data),
        .addr_in    (addr_in),
        .data_in    (data_in),
        .regwrite   (regwrite),
        .frame_done (frame_done),
        .frame_ok   (frame_ok),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (regwrite) obs_q.push_back({16'(addr_in), data_in});
        if (frame_done) begin
            done_cyc.push_back(cyc);
            done_ok.push_back(frame_ok);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        px_en   = 1'b1;
        px_data = b;
        tick();
        px_en   = 1'b0;
        px_data = 8'($urandom);
        if (gap) repeat ($urandom_range(0, 1)) tick();
    endtask

    task automatic add_line(input int len);
        q_len.push_back(len);
        for (int i = 0; i < len; i++) q_bytes.push_back(8'($urandom));
    endtask

    // Frame-level reference: pairs of bytes per line become words, an odd
    // tail is dropped and marks the frame bad, words past a full frame are lost.
    task automatic model(input bit collide, output bit ok);
        int idx = 0;
        int words = 0;
        bit ovf = 0;
        bit lerr = 0;
        exp_q.delete();
        for (int l = 0; l < q_len.size(); l++) begin
            bit last_col = collide && (l == q_len.size() - 1);
            int eff = last_col ? q_len[l] - 1 : q_len[l];
            if ((eff % 2) == 1 && !last_col) lerr = 1;
            for (int p = 0; p + 1 < eff; p += 2) begin
                if (words < NW) begin
                    exp_q.push_back({16'(words), q_bytes[idx + p], q_bytes[idx + p + 1]});
                    words++;
                end else begin
                    ovf = 1;
                end
            end
            idx += q_len[l];
        end
        ok = (words == NW) && !ovf && !lerr;
    endtask

    task automatic run_frame(input bit collide, input bit cap, input bit drop_en);
        int idx = 0;
        int n0 = 0;
        int d0;
        int o0;
        bit exp_ok;
        logic [31:0] o;
        model(collide, exp_ok);
        if (!cap) exp_q.delete();
        o0 = obs_q.size();
        d0 = done_cyc.size();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
        for (int l = 0; l < q_len.size(); l++) begin
            bit last_col = collide && (l == q_len.size() - 1);
            href = 1'b1;
            for (int b = 0; b < q_len[l]; b++) begin
                if (last_col && b == q_len[l] - 1) begin
                    vsync = 1'b1;
                    n0 = cyc;
                    send_byte(q_bytes[idx + b], 1'b0);
                end else begin
                    send_byte(q_bytes[idx + b], 1'b1);
                end
            end
            href = 1'b0;
            if (!last_col) begin
                px_en = 1'b1;
                tick();
                px_en = 1'b0;
                repeat (3) tick();
            end
            if (l == 0) begin
                chk("busy_in_frame", 32'(busy), 32'(cap));
                if (drop_en) capture_en = 1'b0;
            end
            idx += q_len[l];
        end
        if (!collide) begin
            vsync = 1'b1;
            n0 = cyc;
        end
        repeat (6) tick();
        chk("wr_count", 32'(obs_q.size() - o0), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            o = (o0 + i < obs_q.size()) ? obs_q[o0 + i] : 32'hxxxx_xxxx;
            chk("wr_word", o, exp_q[i]);
        end
        chk("done_count", 32'(done_cyc.size() - d0), cap ? 32'd1 : 32'd0);
        if (cap) begin
            chk("done_latency", (d0 < done_cyc.size()) ? 32'(done_cyc[d0]) : 32'hffff_ffff, 32'(n0 + 2));
            chk("frame_ok", (d0 < done_ok.size()) ? 32'(done_ok[d0]) : 32'hxxxx_xxxx, 32'(exp_ok));
        end
        chk("busy_after", 32'(busy), 32'd0);
        q_bytes.delete();
        q_len.delete();
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_addr", 32'(addr_in), 32'd0);
        chk("rst_data", 32'(data_in), 32'd0);
        chk("rst_done", 32'({frame_done, frame_ok}), 32'd0);

        // bytes before any vsync pulse must be ignored
        capture_en = 1'b1;
        ob0 = obs_q.size();
        href = 1'b1;
        for (int i = 0; i < 4; i++) send_byte(8'(i), 1'b0);
        href = 1'b0;
        repeat (3) tick();
        chk("pre_vsync_writes", 32'(obs_q.size() - ob0), 32'd0);
        chk("pre_vsync_busy", 32'(busy), 32'd0);

        // nominal ramp frame
        for (int i = 0; i < 16; i++) q_bytes.push_back(8'(i));
        q_len.push_back(8);
        q_len.push_back(8);
        run_frame(1'b0, 1'b1, 1'b0);

        // overrun
        add_line(8); add_line(8); add_line(8);
        run_frame(1'b0, 1'b1, 1'b0);
        add_line(8); add_line(8); add_line(2);
        run_frame(1'b0, 1'b1, 1'b0);

        // odd lines
        add_line(7); add_line(8);
        run_frame(1'b0, 1'b1, 1'b0);
        add_line(7); add_line(9); add_line(2);
        run_frame(1'b0, 1'b1, 1'b0);

        // second byte of a pair strobed together with the vsync rise
        add_line(8); add_line(8);
        run_frame(1'b1, 1'b1, 1'b0);

        // random frames
        for (int f = 0; f < 6; f++) begin
            int nl = $urandom_range(1, 3);
            for (int l = 0; l < nl; l++) add_line($urandom_range(5, 10));
            run_frame(1'b0, 1'b1, 1'b0);
        end
        add_line(8); add_line(8);
        run_frame(1'b0, 1'b1, 1'b0);

        // reset mid-frame
        ob0 = obs_q.size();
        vsync = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        repeat (3) tick();
        href = 1'b1;
        for (int i = 0; i < 6; i++) begin
            rb[i] = 8'($urandom);
            send_byte(rb[i], 1'b1);
        end
        rst = 1'b1;
        tick();
        chk("midrst_regwrite", 32'(regwrite), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_addr", 32'(addr_in), 32'd0);
        chk("midrst_data", 32'(data_in), 32'd0);
        rst = 1'b0;
        for (int i = 6; i < 12; i++) begin
            rb[i] = 8'($urandom);
            send_byte(rb[i], 1'b1);
        end
        href = 1'b0;
        repeat (4) tick();
        chk("midrst_wr_count", 32'(obs_q.size() - ob0), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("midrst_wr_word", (ob0 + i < obs_q.size()) ? obs_q[ob0 + i] : 32'hxxxx_xxxx,
                {16'(i), rb[2 * i], rb[2 * i + 1]});
        end
        add_line(8); add_line(8);
        run_frame(1'b0, 1'b1, 1'b0);

        // capture_en dropped mid-frame: frame completes, then nothing more
        add_line(8); add_line(8);
        run_frame(1'b0, 1'b1, 1'b1);
        add_line(8); add_line(8);
        run_frame(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
